uart_tx_frame: RTL

Parametrised UART transmitter with an integrated transmit FIFO, configurable data width, stop-bit count and optional parity. It sits between a byte-producing datapath (e.g. the downsampler output stage) and the board serial pin. Producers write words through a valid/ready handshake. The block serialises frames back-to-back with no idle gap while the FIFO holds data.

---
 rtl/uart_tx_frame.sv | 253 +++++++++++++++++++++++++
 1 files changed

// File: rtl/uart_tx_frame.sv
// -----------------------------------------------------------------------------
// uart_tx_frame
//
// UART transmitter with an integrated transmit FIFO. Producers push words
// through a valid/ready handshake; the serialiser sends frames back-to-back
// (no idle gap) for as long as the FIFO holds data.
//
// Frame on o_Tx_Serial: start(0), DATA_BITS data bits LSB first,
// optional parity bit, STOP_BITS stop bits(1). Each bit lasts CLKS_PER_BIT clocks.
//
// Optional feature macro: UART_TX_PARITY_EN
//   defined   -> a parity bit (XOR of data bits, XOR PARITY_ODD) follows DATA
//   undefined -> no parity state or logic; PARITY_ODD has no effect
//
// Ports:
//   i_Clock       system clock, rising edge
//   i_Rst_n       asynchronous active-low reset
//   i_Tx_DV       write valid
//   i_Tx_Byte     write data (DATA_BITS wide)
//   o_Tx_Ready    FIFO not full; write accepted when i_Tx_DV && o_Tx_Ready
//   o_Fifo_Count  FIFO occupancy
//   o_Tx_Serial   serial line, registered, idles high
//   o_Tx_Active   high while the serialiser is not idle
//   o_Tx_Done     one-cycle pulse after the last stop-bit cycle of a frame
// -----------------------------------------------------------------------------
module uart_tx_frame #(
    parameter int CLKS_PER_BIT = 87,
    parameter int DATA_BITS    = 8,
    parameter int STOP_BITS    = 1,
    parameter int FIFO_DEPTH   = 4,
    parameter int PARITY_ODD   = 0
) (
    input  logic                          i_Clock,
    input  logic                          i_Rst_n,
    input  logic                          i_Tx_DV,
    input  logic [DATA_BITS-1:0]          i_Tx_Byte,
    output logic                          o_Tx_Ready,
    output logic [$clog2(FIFO_DEPTH):0]   o_Fifo_Count,
    output logic                          o_Tx_Serial,
    output logic                          o_Tx_Active,
    output logic                          o_Tx_Done
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(CLKS_PER_BIT * STOP_BITS);
    localparam int IDX_W = $clog2(DATA_BITS);

    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] STOP_LAST = CNT_W'(CLKS_PER_BIT * STOP_BITS - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_BITS - 1);

    // Reject illegal configurations at elaboration time.
    if (CLKS_PER_BIT < 2 || DATA_BITS < 5 || DATA_BITS > 9 ||
        (STOP_BITS != 1 && STOP_BITS != 2) || FIFO_DEPTH < 2 ||
        (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 ||
        PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_bad_params
        $error("uart_tx_frame: illegal parameter combination");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_TX_PARITY_EN
        S_PARITY,
`endif
        S_STOP
    } state_e;

    // ------------------------------------------------------------------ FIFO
    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
    logic [PTR_W:0]       wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0]       rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]       count_q, count_d;
    logic                 ready_q, ready_d;
    logic                 fifo_empty;
    logic                 push;
    logic                 pop;
    logic [DATA_BITS-1:0] head;

    assign fifo_empty = (count_q == '0);
    assign push       = i_Tx_DV && ready_q;
    assign head       = mem_q[rd_ptr_q[PTR_W-1:0]];

    // NOTE: the storage array has no reset; only the pointers define which
    // entries are valid, so clearing the data would buy nothing.
    always_ff @(posedge i_Clock) begin
        if (push) begin
            mem_q[wr_ptr_q[PTR_W-1:0]] <= i_Tx_Byte;
        end
    end

    // ------------------------------------------------------------ serialiser
    state_e               state_q, state_d;
    logic [CNT_W-1:0]     clk_cnt_q, clk_cnt_d;
    logic [IDX_W-1:0]     bit_idx_q, bit_idx_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 serial_q, serial_d;
    logic                 active_q, active_d;
    logic                 done_q, done_d;
`ifdef UART_TX_PARITY_EN
    logic                 parity_q, parity_d;
`endif

    // NOTE: every signal assigned below gets a default first, so no path
    // through the case statement can leave a value held (no latches).
    always_comb begin
        state_d   = state_q;
        clk_cnt_d = clk_cnt_q + 1'b1;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        serial_d  = serial_q;
        done_d    = 1'b0;
        pop       = 1'b0;
`ifdef UART_TX_PARITY_EN
        parity_d  = parity_q;
`endif

        case (state_q)
            S_IDLE: begin
                clk_cnt_d = '0;
                serial_d  = 1'b1;
                if (!fifo_empty) begin
                    pop      = 1'b1;
                    state_d  = S_START;
                    serial_d = 1'b0;
                end
            end

            S_START: begin
                if (clk_cnt_q == BIT_LAST) begin
                    clk_cnt_d = '0;
                    state_d   = S_DATA;
                    serial_d  = shift_q[0];
                end
            end

            S_DATA: begin
                if (clk_cnt_q == BIT_LAST) begin
                    clk_cnt_d = '0;
                    if (bit_idx_q == IDX_LAST) begin
`ifdef UART_TX_PARITY_EN
                        state_d  = S_PARITY;
                        serial_d = parity_q;
`else
                        state_d  = S_STOP;
                        serial_d = 1'b1;
`endif
                    end else begin
                        // Shift so the next data bit is always at bit 0.
                        bit_idx_d = bit_idx_q + 1'b1;
                        shift_d   = shift_q >> 1;
                        serial_d  = shift_q[1];
                    end
                end
            end

`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                if (clk_cnt_q == BIT_LAST) begin
                    clk_cnt_d = '0;
                    state_d   = S_STOP;
                    serial_d  = 1'b1;
                end
            end
`endif

            S_STOP: begin
                if (clk_cnt_q == STOP_LAST) begin
                    clk_cnt_d = '0;
                    done_d    = 1'b1;
                    // Chain straight into the next start bit when data waits.
                    if (!fifo_empty) begin
                        pop      = 1'b1;
                        state_d  = S_START;
                        serial_d = 1'b0;
                    end else begin
                        state_d  = S_IDLE;
                        serial_d = 1'b1;
                    end
                end
            end

            default: begin
                state_d   = S_IDLE;
                clk_cnt_d = '0;
                serial_d  = 1'b1;
            end
        endcase

        // Loading the head word is shared by the IDLE and STOP pop paths.
        if (pop) begin
            shift_d   = head;
            bit_idx_d = '0;
`ifdef UART_TX_PARITY_EN
            parity_d  = (^head) ^ (PARITY_ODD != 0);
`endif
        end

        active_d = (state_d != S_IDLE);

        wr_ptr_d = wr_ptr_q + (PTR_W + 1)'(push);
        rd_ptr_d = rd_ptr_q + (PTR_W + 1)'(pop);
        count_d  = wr_ptr_d - rd_ptr_d;
        // Full: wrap bits differ while the address bits match.
        ready_d  = !((wr_ptr_d[PTR_W] != rd_ptr_d[PTR_W]) &&
                     (wr_ptr_d[PTR_W-1:0] == rd_ptr_d[PTR_W-1:0]));
    end

    // NOTE: non-blocking assignments make every flop sample the pre-edge
    // values, so the order of these statements does not matter.
    always_ff @(posedge i_Clock or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            state_q   <= S_IDLE;
            clk_cnt_q <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            serial_q  <= 1'b1;
            active_q  <= 1'b0;
            done_q    <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_q  <= 1'b0;
`endif
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            ready_q   <= 1'b1;
        end else begin
            state_q   <= state_d;
            clk_cnt_q <= clk_cnt_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            serial_q  <= serial_d;
            active_q  <= active_d;
            done_q    <= done_d;
`ifdef UART_TX_PARITY_EN
            parity_q  <= parity_d;
`endif
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            ready_q   <= ready_d;
        end
    end

    assign o_Tx_Ready   = ready_q;
    assign o_Fifo_Count = count_q;
    assign o_Tx_Serial  = serial_q;
    assign o_Tx_Active  = active_q;
    assign o_Tx_Done    = done_q;

endmodule
